// File: rtl/serial_core_sequencer.sv
// serial_core_sequencer: multi-cycle RV32I/RV32E control sequencer.
// Owns PC, IR, register file and the instruction FSM. The nibble-serial
// ALU and the memory are external, reached via start/done and req/ack
// handshakes respectively.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses halt with
// err=1 instead of being truncated to natural alignment.

module serial_core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NREGS       = 32,
  parameter int          MEM_LAT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        alu_start,
  output logic [2:0]  alu_funct3,
  output logic        alu_sub,
  output logic [31:0] alu_w1,
  output logic [31:0] alu_w2,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  output logic        halted,
  output logic        err
);

  localparam int RIDX_W = $clog2(NREGS);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD     = 3'b000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_PC_INC,
    S_DECODE,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] wb_val;
  logic [31:0] tcount;
  logic [1:0]  ldst_off;
  logic [31:0] regs [NREGS];

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [RIDX_W-1:0] rd_idx;
  logic [RIDX_W-1:0] rs1_idx;
  logic [RIDX_W-1:0] rs2_idx;
  logic [31:0]       rs1_val;
  logic [31:0]       rs2_val;
  logic [31:0]       imm_i;
  logic [31:0]       imm_s;
  logic [31:0]       imm_u;

  // Instruction field decode; index bits above log2(NREGS) are dropped.
  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign rd_idx  = ir[7 +: RIDX_W];
  assign rs1_idx = ir[15 +: RIDX_W];
  assign rs2_idx = ir[20 +: RIDX_W];
  assign rs1_val = (rs1_idx == '0) ? 32'h0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? 32'h0 : regs[rs2_idx];
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_u   = {ir[31:12], 12'h000};

  // Byte enables for a store; half offsets are forced even.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the enables pick the right one.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] v);
    case (f3[1:0])
      2'b00:   store_data = {4{v[7:0]}};
      2'b01:   store_data = {2{v[15:0]}};
      default: store_data = v;
    endcase
  endfunction

  // Lane select and sign/zero extension of a returned read word.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'h0, b};
      3'b101:  load_extract = {16'h0, h};
      default: load_extract = w;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction
`endif

  // Instruction state machine, register file and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      wb_val     <= '0;
      tcount     <= '0;
      ldst_off   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      alu_start  <= 1'b0;
      alu_funct3 <= '0;
      alu_sub    <= 1'b0;
      alu_w1     <= '0;
      alu_w2     <= '0;
      halted     <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (mem_req && !mem_ack && (tcount >= 32'(MEM_LAT_MAX))) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_be  <= '0;
      halted  <= 1'b1;
      err     <= 1'b1;
      state   <= S_HALT;
    end else begin
      if (mem_req) tcount <= tcount + 32'd1;
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            mem_addr <= {pc[31:2], 2'b00};
            tcount   <= '0;
          end else if (mem_ack) begin
            ir         <= mem_rdata;
            mem_req    <= 1'b0;
            alu_start  <= 1'b1;
            alu_funct3 <= F3_ADD;
            alu_sub    <= 1'b0;
            alu_w1     <= pc;
            alu_w2     <= 32'd4;
            state      <= S_PC_INC;
          end
        end
        S_PC_INC: begin
          alu_start <= 1'b0;
          if (!alu_start && alu_done) begin
            pc    <= alu_result;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OPC_OP_IMM, OPC_OP: begin
              alu_start  <= 1'b1;
              alu_funct3 <= funct3;
              alu_w1     <= rs1_val;
              if (opcode == OPC_OP) begin
                alu_w2  <= rs2_val;
                alu_sub <= ((funct3 == 3'b000) || (funct3 == 3'b101)) ? ir[30] : 1'b0;
              end else begin
                alu_w2  <= imm_i;
                alu_sub <= (funct3 == 3'b101) ? ir[30] : 1'b0;
              end
              state <= S_EXEC;
            end
            OPC_LOAD, OPC_STORE: begin
              alu_start  <= 1'b1;
              alu_funct3 <= F3_ADD;
              alu_sub    <= 1'b0;
              alu_w1     <= rs1_val;
              alu_w2     <= (opcode == OPC_LOAD) ? imm_i : imm_s;
              state      <= S_EXEC;
            end
            OPC_LUI: begin
              wb_val <= imm_u;
              state  <= S_WB;
            end
            OPC_SYSTEM: begin
              halted <= 1'b1;
              err    <= 1'b0;
              state  <= S_HALT;
            end
            default: begin
              halted <= 1'b1;
              err    <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          alu_start <= 1'b0;
          if (!alu_start && alu_done) begin
            ldst_off <= alu_result[1:0];
            if (opcode == OPC_LOAD) begin
`ifdef MISALIGN_TRAP_EN
              if (misaligned(funct3, alu_result[1:0])) begin
                halted <= 1'b1;
                err    <= 1'b1;
                state  <= S_HALT;
              end else
`endif
              begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {alu_result[31:2], 2'b00};
                tcount   <= '0;
                state    <= S_MEM_RD;
              end
            end else if (opcode == OPC_STORE) begin
`ifdef MISALIGN_TRAP_EN
              if (misaligned(funct3, alu_result[1:0])) begin
                halted <= 1'b1;
                err    <= 1'b1;
                state  <= S_HALT;
              end else
`endif
              begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {alu_result[31:2], 2'b00};
                mem_be    <= store_be(funct3, alu_result[1:0]);
                mem_wdata <= store_data(funct3, rs2_val);
                tcount    <= '0;
                state     <= S_MEM_WR;
              end
            end else begin
              wb_val <= alu_result;
              state  <= S_WB;
            end
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            wb_val  <= load_extract(funct3, ldst_off, mem_rdata);
            mem_req <= 1'b0;
            state   <= S_WB;
          end
        end
        S_MEM_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            state   <= S_FETCH;
          end
        end
        S_WB: begin
          if (rd_idx != '0) regs[rd_idx] <= wb_val;
          state <= S_FETCH;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_core_sequencer.md
Name: serial_core_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the RV32 core built around the nibble-serial ALU.
- Owns PC, instruction register, register file and the instruction state machine; drives the external serial ALU through a start/done handshake.
- Accesses an external memory through a req/ack handshake instead of an internal array.
- Adds full-width loads and stores (byte/half/word, signed/unsigned), register-register OP, LUI, a configurable register count and a configurable reset vector.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, register count: 32 (RV32I) or 16 (RV32E). Register index bits above log2(NREGS) are ignored.
- MEM_LAT_MAX, 255, ack timeout in cycles; exceeding it enters HALT with err=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write
- mem_addr  out  32  byte address, word-aligned (low 2 bits always 0)
- mem_be  out  4  byte enables (writes only; reads return full word)
- mem_wdata  out  32  write data, lane-shifted
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- alu_start  out  1  one-cycle start pulse
- alu_funct3  out  3  ALU operation
- alu_sub  out  1  subtract/arith-shift modifier
- alu_w1  out  32  operand 1, stable from alu_start until alu_done
- alu_w2  out  32  operand 2, stable from alu_start until alu_done
- alu_result  in  32  result, valid with alu_done
- alu_done  in  1  one-cycle completion pulse
- halted  out  1  sequencer stopped
- err  out  1  stop caused by an error

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, all registers 0.
  - mem_req=0, mem_we=0, mem_be=0, alu_start=0, halted=0, err=0.
  - mem_addr, mem_wdata, alu_w1, alu_w2 read 0.
  - Reset mid-handshake abandons the transaction; a late ack or done is ignored.
- x0 reads 0 always; writes to x0 are discarded.
- FETCH:
  - mem_req=1, mem_addr=pc, mem_we=0.
  - On mem_ack: ir<=mem_rdata, go to PC_INC.
- PC_INC:
  - alu_start pulse with w1=pc, w2=4, funct3=ADD.
  - On alu_done: pc<=alu_result, go to DECODE.
- DECODE (1 cycle), by opcode:
  - OP_IMM/OP: go to EXEC with w1=rs1, w2=imm or rs2.
  - LOAD/STORE: go to EXEC with w1=rs1, w2=imm and funct3 forced to ADD.
  - LUI: go directly to WB with value=imm.
  - SYSTEM: go to HALT with err=0.
  - Any other opcode: go to HALT with err=1.
- EXEC:
  - alu_start pulse; wait for alu_done.
  - OP/OP_IMM go to WB; LOAD goes to MEM_RD; STORE goes to MEM_WR.
  - Result and address are latched on alu_done.
- MEM_RD:
  - mem_addr = {addr[31:2],2'b00}.
  - On ack, select byte/half by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU; go to WB.
- MEM_WR:
  - mem_we=1; mem_be = 0001<<a (SB), 0011<<a (SH), 1111 (SW).
  - mem_wdata = rs2 replicated into the lanes.
  - On ack go to FETCH; no register write.
- WB: register write of rd; go to FETCH next cycle.
- HALT: absorbing; only reset exits.
- Minimum instruction latency = 1 + ack wait + ALU time ×2 + 2 cycles.
- alu_start is never asserted while an ALU op is outstanding.
- alu_done arriving in a state not waiting for it: ignored.
- Ack timeout: a counter resets on each new request; if it reaches MEM_LAT_MAX, go to HALT with err=1.
- Fetch at pc=0xFFFF_FFFC increments to 0 (wraps, no error).

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1 → HALT, err=1.
  - LW/SW with addr[1:0]≠0 → HALT, err=1.
  - No memory request is issued in either case.
- Undefined: low address bits are silently truncated to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds.

Test Plan:
- Program `addi x5,x0,123; addi x6,x5,2; ecall`, with RESET_PC=0xAEF and a 1-cycle ack → x5=123, x6=125, halted=1, err=0.
- `lb x7,1(x5)` with x5=0x80 and word 0x80 = 0x0000_F200, then `lbu x8,1(x5)` → x7=0xFFFF_FFF2, x8=0x0000_00F2.
- `sh x6,2(x5)` with x6=0x1234, x5=0x80 → one write: addr 0x80, be=1100, wdata[31:16]=0x1234.
- Random 0–10-cycle ack delays plus a reset pulse during a FETCH wait → pc=RESET_PC, mem_req=0; the late ack is ignored; the program completes correctly.
- Opcode 0x63 (branch) → halted=1, err=1, pc = instruction address+4.
- `lw x9,2(x0)` → MISALIGN_TRAP_EN defined: err=1, no mem_req. Undefined: reads word at address 0.
